snoopy_game_ctrl: RTL and testbench

SNOOPY_GAME_CTRL -- requirements
Module: snoopy_game_ctrl

---
 rtl/snoopy_pkg.sv | 29 ++
 rtl/snoopy_motion.sv | 46 ++++
 rtl/snoopy_game_ctrl.sv | 139 +++++++++++++
 tb/tb_snoopy_game_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snoopy_pkg.sv
// Shared definitions for the Snoopy runner game controller: FSM state
// encoding, game_state codes and playfield geometry constants.
package snoopy_pkg;

  localparam logic [7:0] X_START     = 8'd4;
  localparam logic [6:0] GROUND_Y    = 7'd100;
  localparam logic [7:0] X_MAX       = 8'd159;
  localparam int         SPRITE_SIZE = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAW,
    ST_DRAW_WAIT,
    ST_WAIT_FRAME,
    ST_ERASE,
    ST_ERASE_WAIT,
    ST_MOVE,
    ST_SETTLE,
    ST_LOSE,
    ST_WIN
  } state_t;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_RUN  = 2'b01;
  localparam logic [1:0] GS_LOSE = 2'b10;
  localparam logic [1:0] GS_WIN  = 2'b11;

endpackage

// File: rtl/snoopy_motion.sv
// Player position and jump trajectory: one step per frame, with a
// down-counting ascent timer followed by a fall back to the ground line.
module snoopy_motion #(
  parameter logic [7:0] X_START     = snoopy_pkg::X_START,
  parameter logic [6:0] GROUND_Y    = snoopy_pkg::GROUND_Y,
  parameter logic [7:0] X_MAX       = snoopy_pkg::X_MAX,
  parameter int         JUMP_FRAMES = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic       step,
  input  logic       jump,
  output logic [7:0] x,
  output logic [6:0] y
);

  localparam int JC_W = $clog2(JUMP_FRAMES + 1);

  logic [JC_W-1:0] jump_cnt;

  // All three vertical cases look at the pre-step counter, so the frame
  // that launches a jump leaves y on the ground.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x        <= X_START;
      y        <= GROUND_Y;
      jump_cnt <= '0;
    end else if (load) begin
      x        <= X_START;
      y        <= GROUND_Y;
      jump_cnt <= '0;
    end else if (step) begin
      x <= (x >= X_MAX) ? X_MAX : x + 8'd1;
      if (jump && (y == GROUND_Y) && (jump_cnt == '0)) begin
        jump_cnt <= JC_W'(JUMP_FRAMES);
      end else if (jump_cnt != '0) begin
        y        <= y - 7'd1;
        jump_cnt <= jump_cnt - JC_W'(1);
      end else if (y < GROUND_Y) begin
        y <= y + 7'd1;
      end
    end
  end

endmodule

// File: rtl/snoopy_game_ctrl.sv
// Game sequencing FSM: draw/erase handshakes with the renderer, one motion
// step per frame, and collision/end-of-screen evaluation after each step.
//
// state      | meaning
// IDLE       | waiting for start, position held at start point
// CLEAR      | 1 cycle: clear collision checker, reload position
// DRAW       | raise draw_req for sprite
// DRAW_WAIT  | hold sprite request until draw_done
// WAIT_FRAME | sprite on screen, waiting for frame_tick
// ERASE      | raise draw_req for background
// ERASE_WAIT | hold erase request until draw_done
// MOVE       | 1 cycle: advance x, apply jump/fall
// SETTLE     | 2 cycles: let collision checker catch up, then decide
// LOSE       | obstacle hit, waiting for start
// WIN        | end of screen reached, waiting for start
module snoopy_game_ctrl #(
  parameter logic [7:0] X_START     = snoopy_pkg::X_START,
  parameter logic [6:0] GROUND_Y    = snoopy_pkg::GROUND_Y,
  parameter int         JUMP_FRAMES = 16,
  parameter logic [7:0] X_MAX       = snoopy_pkg::X_MAX
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       jump,
  input  logic       frame_tick,
  input  logic       collided,
  input  logic       reached_screen_end,
  input  logic       draw_done,
  output logic [7:0] x_c,
  output logic [6:0] y_c,
  output logic       draw_req,
  output logic       erase,
  output logic       coll_resetn,
  output logic [1:0] game_state
);

  import snoopy_pkg::*;

  state_t state, state_nx;
  logic   settle_cnt;
  logic   load, step;

  snoopy_motion #(
    .X_START    (X_START),
    .GROUND_Y   (GROUND_Y),
    .X_MAX      (X_MAX),
    .JUMP_FRAMES(JUMP_FRAMES)
  ) u_motion (
    .clock (clock),
    .resetn(resetn),
    .load  (load),
    .step  (step),
    .jump  (jump),
    .x     (x_c),
    .y     (y_c)
  );

  // coll_resetn is registered so it is low exactly while in CLEAR and
  // comes out of reset one edge after resetn releases.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      settle_cnt  <= 1'b0;
      coll_resetn <= 1'b0;
    end else begin
      state       <= state_nx;
      coll_resetn <= (state_nx != ST_CLEAR);
      if (state == ST_MOVE) begin
        settle_cnt <= 1'b1;
      end else if ((state == ST_SETTLE) && (settle_cnt != 1'b0)) begin
        settle_cnt <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    draw_req   = 1'b0;
    erase      = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    game_state = GS_RUN;
    case (state)
      ST_IDLE: begin
        load       = 1'b1;
        game_state = GS_IDLE;
        if (start) state_nx = ST_CLEAR;
      end
      ST_CLEAR: begin
        load     = 1'b1;
        state_nx = ST_DRAW;
      end
      ST_DRAW: begin
        draw_req = 1'b1;
        state_nx = ST_DRAW_WAIT;
      end
      ST_DRAW_WAIT: begin
        draw_req = 1'b1;
        if (draw_done) state_nx = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (frame_tick) state_nx = ST_ERASE;
      end
      ST_ERASE: begin
        draw_req = 1'b1;
        erase    = 1'b1;
        state_nx = ST_ERASE_WAIT;
      end
      ST_ERASE_WAIT: begin
        draw_req = 1'b1;
        erase    = 1'b1;
        if (draw_done) state_nx = ST_MOVE;
      end
      ST_MOVE: begin
        step     = 1'b1;
        state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        // A hit takes priority over reaching the end of the screen.
        if (settle_cnt == 1'b0) begin
          if (collided)                state_nx = ST_LOSE;
          else if (reached_screen_end) state_nx = ST_WIN;
          else                         state_nx = ST_DRAW;
        end
      end
      ST_LOSE: begin
        game_state = GS_LOSE;
        if (start) state_nx = ST_CLEAR;
      end
      ST_WIN: begin
        game_state = GS_WIN;
        if (start) state_nx = ST_CLEAR;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_snoopy_game_ctrl.sv
// Directed bench for snoopy_game_ctrl: renderer requests are checked against
// a queue of expected (erase, x, y) entries built from a small position model.
module tb_snoopy_game_ctrl;

  localparam int X0 = 4;
  localparam int GY = 100;
  localparam int JF = 16;
  localparam int XM = 159;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       jump = 1'b0;
  logic       frame_tick = 1'b0;
  logic       collided = 1'b0;
  logic       reached_screen_end = 1'b0;
  logic       draw_done = 1'b0;
  logic [7:0] x_c;
  logic [6:0] y_c;
  logic       draw_req;
  logic       erase;
  logic       coll_resetn;
  logic [1:0] game_state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       erase;
    logic [7:0] x;
    logic [6:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   mx, my, mjc;

  snoopy_game_ctrl dut (
    .clock             (clock),
    .resetn            (resetn),
    .start             (start),
    .jump              (jump),
    .frame_tick        (frame_tick),
    .collided          (collided),
    .reached_screen_end(reached_screen_end),
    .draw_done         (draw_done),
    .x_c               (x_c),
    .y_c               (y_c),
    .draw_req          (draw_req),
    .erase             (erase),
    .coll_resetn       (coll_resetn),
    .game_state        (game_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic er);
    exp_t ev;
    ev.erase = er;
    ev.x     = 8'(mx);
    ev.y     = 7'(my);
    exp_q.push_back(ev);
  endtask

  task automatic model_reset();
    mx = X0; my = GY; mjc = 0;
  endtask

  task automatic model_move(input bit jmp);
    int old_c;
    old_c = mjc;
    if (jmp && my == GY && old_c == 0) mjc = JF;
    else if (old_c > 0) begin my--; mjc--; end
    else if (my < GY) my++;
    mx = (mx >= XM) ? XM : mx + 1;
  endtask

  // Entered at a negedge; returns at the negedge after draw_done was sampled.
  task automatic serve_req(input int dly, input bit mid_tick);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (draw_req === 1'b1) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    if (!seen) begin
      chk("req_timeout", {31'b0, draw_req}, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("queue_underflow", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    chk("req_erase", {31'b0, erase}, {31'b0, e.erase});
    chk("req_x", {24'b0, x_c}, {24'b0, e.x});
    chk("req_y", {25'b0, y_c}, {25'b0, e.y});
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      frame_tick = mid_tick && (i == 0);
      chk("req_hold", {31'b0, draw_req}, 1);
      chk("hold_x", {24'b0, x_c}, {24'b0, e.x});
    end
    frame_tick = 1'b0;
    draw_done  = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    chk("req_drop", {31'b0, draw_req}, 0);
  endtask

  // Entered and left in WAIT_FRAME (or LOSE/WIN when an end flag is given).
  task automatic do_frame(input bit jmp, input int dly, input bit coll, input bit rse,
                          input bit mid_tick);
    push_exp(1'b1);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    jump = jmp;
    serve_req(dly, mid_tick);
    collided = coll;
    reached_screen_end = rse;
    @(negedge clock);
    jump = 1'b0;
    model_move(jmp);
    chk("move_x", {24'b0, x_c}, mx);
    chk("move_y", {25'b0, y_c}, my);
    if (coll || rse) begin
      @(negedge clock);
      chk("settle_gs", {30'b0, game_state}, 1);
      @(negedge clock);
      chk("end_gs", {30'b0, game_state}, coll ? 2 : 3);
      chk("end_req", {31'b0, draw_req}, 0);
      chk("end_x", {24'b0, x_c}, mx);
      chk("end_y", {25'b0, y_c}, my);
      collided = 1'b0;
      reached_screen_end = 1'b0;
    end else begin
      push_exp(1'b0);
      serve_req(dly, 1'b0);
      if (mid_tick) begin
        repeat (4) @(negedge clock);
        chk("tick_dropped", {31'b0, draw_req}, 0);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_x", {24'b0, x_c}, X0);
    chk("rst_y", {25'b0, y_c}, GY);
    chk("rst_req", {31'b0, draw_req}, 0);
    chk("rst_erase", {31'b0, erase}, 0);
    chk("rst_coll", {31'b0, coll_resetn}, 0);
    chk("rst_gs", {30'b0, game_state}, 0);

    resetn = 1'b1;
    @(negedge clock);
    chk("coll_release", {31'b0, coll_resetn}, 1);
    chk("idle_gs", {30'b0, game_state}, 0);

    push_exp(1'b0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("clear_coll", {31'b0, coll_resetn}, 0);
    chk("clear_gs", {30'b0, game_state}, 1);
    @(negedge clock);
    chk("clear_one_cycle", {31'b0, coll_resetn}, 1);
    serve_req(3, 1'b0);

    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("start_ignored_gs", {30'b0, game_state}, 1);
    chk("start_ignored_req", {31'b0, draw_req}, 0);

    repeat (3) do_frame(1'b0, 3, 1'b0, 1'b0, 1'b0);
    chk("three_x", {24'b0, x_c}, 7);
    chk("three_y", {25'b0, y_c}, 100);

    while (mx < 10) do_frame(1'b0, 2, 1'b0, 1'b0, 1'b0);
    do_frame(1'b1, 2, 1'b0, 1'b0, 1'b0);
    for (int f = 1; f <= 32; f++) begin
      do_frame((f == 5) || (f == 20), 1, 1'b0, 1'b0, 1'b0);
      if (f == 16) chk("apex_y", {25'b0, y_c}, 84);
    end
    chk("landed_y", {25'b0, y_c}, 100);
    chk("landed_x", {24'b0, x_c}, 43);

    do_frame(1'b0, 2, 1'b1, 1'b1, 1'b0);
    model_reset();
    push_exp(1'b0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("restart_gs", {30'b0, game_state}, 1);
    chk("restart_coll", {31'b0, coll_resetn}, 0);
    @(negedge clock);
    chk("restart_x", {24'b0, x_c}, X0);
    chk("restart_y", {25'b0, y_c}, GY);
    serve_req(2, 1'b0);

    while (mx < XM) do_frame(1'b0, 1, 1'b0, 1'b0, 1'b0);
    do_frame(1'b0, 1, 1'b0, 1'b0, 1'b0);
    chk("sat_x", {24'b0, x_c}, 159);
    do_frame(1'b0, 1, 1'b0, 1'b1, 1'b0);

    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("pre_reset_req", {31'b0, draw_req}, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_req", {31'b0, draw_req}, 0);
    chk("async_gs", {30'b0, game_state}, 0);
    chk("async_coll", {31'b0, coll_resetn}, 0);
    chk("async_x", {24'b0, x_c}, X0);
    @(negedge clock);
    resetn = 1'b1;
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
    chk("stray_done_gs", {30'b0, game_state}, 0);
    chk("stray_done_req", {31'b0, draw_req}, 0);

    model_reset();
    push_exp(1'b0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    serve_req(2, 1'b0);
    do_frame(1'b0, 3, 1'b0, 1'b0, 1'b1);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
